// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encoding and the access legality check used at request accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    WR_WAIT,
    RESP,
    ERR
  } lsu_state_e;

  // True when funct3 is a legal load/store encoding and the address meets
  // the natural alignment of the access size. Stores have no unsigned forms.
  function automatic logic accessOk(input logic isStore,
                                    input logic [2:0] funct3,
                                    input logic [1:0] addrLo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !isStore;
      F3_H:    ok = !addrLo[0];
      F3_HU:   ok = !isStore && !addrLo[0];
      F3_W:    ok = (addrLo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundles around the load/store unit: the CPU request/response side and
// the word-wide single-port data memory side.
interface lsu_cpu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_request;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_request, mem_we, mem_addr, mem_wdata,
    input  mem_valid, mem_rdata
  );

  modport slave (
    input  mem_request, mem_we, mem_addr, mem_wdata,
    output mem_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a memory word and sub-word CPU data: extracts
// and extends load data, and merges store data into a read word. Purely
// combinational so it can also sit on the cache refill path.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            addrLo_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] loadData_o,
  output logic [DATA_WIDTH-1:0] storeWord_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Select the addressed byte and half-word lanes of the memory word
  always_comb begin
    byteSel = word_i[{addrLo_i, 3'b000} +: 8];
    halfSel = addrLo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Sign- or zero-extend the selected lane; full words pass straight through
  always_comb begin
    case (funct3_i)
      F3_B:    loadData_o = {{24{byteSel[7]}}, byteSel};
      F3_BU:   loadData_o = {24'h000000, byteSel};
      F3_H:    loadData_o = {{16{halfSel[15]}}, halfSel};
      F3_HU:   loadData_o = {16'h0000, halfSel};
      default: loadData_o = word_i;
    endcase
  end

  // Overlay right-aligned store data onto the addressed lane(s)
  always_comb begin
    storeWord_o = word_i;
    case (funct3_i)
      F3_B: storeWord_o[{addrLo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H: begin
        if (addrLo_i[1]) storeWord_o[31:16] = wdata_i[15:0];
        else             storeWord_o[15:0]  = wdata_i[15:0];
      end
      default: storeWord_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the CPU MEM stage and a word-wide single-port data
// memory. Sub-word stores become read-modify-write; misaligned or illegal
// requests are answered with an error and never touch memory. All outputs are
// registers or state decodes so nothing on req_* reaches mem_* combinationally.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic        clk,
  input logic        rst_n,
  lsu_cpu_if.slave   cpu,
  lsu_mem_if.master  mem
);

  if (DATA_WIDTH != 32) begin : gWidthCheck
    $error("load_store_unit supports DATA_WIDTH = 32 only");
  end

  lsu_state_e            state_q, state_d;
  logic                  isStore_q, isStore_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] wrWord_q, wrWord_d;
  logic [DATA_WIDTH-1:0] respRdata_q, respRdata_d;

  logic                  accept;
  logic                  accessLegal;
  logic [DATA_WIDTH-1:0] loadData;
  logic [DATA_WIDTH-1:0] storeWord;

  assign accept      = cpu.req_valid && (state_q == IDLE);
  assign accessLegal = accessOk(cpu.req_we, cpu.req_funct3, cpu.req_addr[1:0]);

  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) uLaneAlign (
    .funct3_i   (funct3_q),
    .addrLo_i   (addr_q[1:0]),
    .word_i     (mem.mem_rdata),
    .wdata_i    (wdata_q),
    .loadData_o (loadData),
    .storeWord_o(storeWord)
  );

  // State and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      isStore_q   <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wrWord_q    <= '0;
      respRdata_q <= '0;
    end else begin
      state_q     <= state_d;
      isStore_q   <= isStore_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wrWord_q    <= wrWord_d;
      respRdata_q <= respRdata_d;
    end
  end

  // Next-state logic: errors answer at once, SW goes straight to the write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!accessLegal)                             state_d = ERR;
          else if (cpu.req_we && cpu.req_funct3 == F3_W) state_d = WR;
          else                                          state_d = RD;
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: if (mem.mem_valid) state_d = isStore_q ? WR : RESP;
      WR:      state_d = WR_WAIT;
      WR_WAIT: if (mem.mem_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: latch the request, capture merge/load results, and
  // clear the response data for stores and errors
  always_comb begin
    isStore_d   = isStore_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wrWord_d    = wrWord_q;
    respRdata_d = respRdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          isStore_d = cpu.req_we;
          funct3_d  = cpu.req_funct3;
          addr_d    = cpu.req_addr;
          wdata_d   = cpu.req_wdata;
          wrWord_d  = cpu.req_wdata;
          if (!accessLegal) respRdata_d = '0;
        end
      end
      RD_WAIT: begin
        if (mem.mem_valid) begin
          if (isStore_q) wrWord_d    = storeWord;
          else           respRdata_d = loadData;
        end
      end
      WR_WAIT: if (mem.mem_valid) respRdata_d = '0;
      default: ;
    endcase
  end

  // Moore outputs decoded from the current state and registered data
  always_comb begin
    cpu.req_ready   = 1'b0;
    cpu.resp_valid  = 1'b0;
    cpu.resp_err    = 1'b0;
    cpu.resp_rdata  = respRdata_q;
    mem.mem_request = 1'b0;
    mem.mem_we      = 1'b0;
    mem.mem_addr    = '0;
    mem.mem_wdata   = '0;
    case (state_q)
      IDLE: cpu.req_ready = 1'b1;
      RD: begin
        mem.mem_request = 1'b1;
        mem.mem_addr    = {2'b00, addr_q[ADDR_WIDTH-1:2]};
      end
      WR: begin
        mem.mem_request = 1'b1;
        mem.mem_we      = 1'b1;
        mem.mem_addr    = {2'b00, addr_q[ADDR_WIDTH-1:2]};
        mem.mem_wdata   = wrWord_q;
      end
      RESP: cpu.resp_valid = 1'b1;
      ERR: begin
        cpu.resp_valid = 1'b1;
        cpu.resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for the load/store unit with a one-cycle-latency memory
// model and a response scoreboard that also checks response timing.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  lsu_cpu_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cpuBus ();
  lsu_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) memBus ();

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .cpu  (cpuBus),
    .mem  (memBus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  exp_t        expQ[$];
  int          testCount  = 0;
  int          failCount  = 0;
  int          cycleCount = 0;
  int          readCount  = 0;
  int          writeCount = 0;
  int          lastAccept = 0;
  logic [31:0] lastWrAddr = '0;
  logic [31:0] lastWrData = '0;
  logic [31:0] memArray [0:15];
  bit          holdOff     = 1'b0;
  bit          injectValid = 1'b0;

  // Cycle counter used to time responses against their accept cycle
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request, wait for it to be accepted and queue its expected response
  task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic expErr, input logic [31:0] expData,
                               input int lat, input bit keepValid);
    exp_t e;
    int   waitCycles = 0;
    @(negedge clk);
    cpuBus.req_we     = we;
    cpuBus.req_funct3 = f3;
    cpuBus.req_addr   = addr;
    cpuBus.req_wdata  = wdata;
    cpuBus.req_valid  = 1'b1;
    while (!cpuBus.req_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!cpuBus.req_ready) begin
      checkOutput({tag, " req_ready timeout"}, {31'b0, cpuBus.req_ready}, 32'h1);
      cpuBus.req_valid = 1'b0;
      return;
    end
    lastAccept = cycleCount;
    e.tag   = tag;
    e.err   = expErr;
    e.rdata = expData;
    e.cycle = cycleCount + lat;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (!keepValid) cpuBus.req_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput({tag, " drain timeout"}, expQ.size(), 32'h0);
      expQ.delete();
    end
  endtask

  // Scoreboard: every response is matched in order against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && cpuBus.resp_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected resp_valid", {31'b0, cpuBus.resp_valid}, 32'h0);
      end else begin
        e = expQ.pop_front();
        checkOutput({e.tag, " resp_err"}, {31'b0, cpuBus.resp_err}, {31'b0, e.err});
        checkOutput({e.tag, " resp_rdata"}, cpuBus.resp_rdata, e.rdata);
        checkOutput({e.tag, " latency"}, cycleCount, e.cycle);
      end
    end
  end

  // Memory model: a request seen in one cycle is answered in the next
  initial begin
    for (int i = 0; i < 16; i++) memArray[i] = 32'h0;
    memArray[2] = 32'h80FF7F01;
    memArray[3] = 32'hCAFEF00D;
    memBus.mem_valid = 1'b0;
    memBus.mem_rdata = '0;
    forever begin
      bit          pend;
      bit          pWe;
      logic [31:0] pAddr;
      logic [31:0] pData;
      @(negedge clk);
      pend  = 1'b0;
      pWe   = 1'b0;
      pAddr = '0;
      pData = '0;
      if (rst_n && memBus.mem_request) begin
        pWe   = memBus.mem_we;
        pAddr = memBus.mem_addr;
        pData = memBus.mem_wdata;
        if (pWe) begin
          writeCount++;
          lastWrAddr = pAddr;
          lastWrData = pData;
        end else begin
          readCount++;
        end
        pend = !holdOff;
      end
      @(posedge clk);
      #1;
      memBus.mem_valid = pend || injectValid;
      memBus.mem_rdata = injectValid ? 32'h55555555 : 32'h0;
      if (pend) begin
        if (pWe) memArray[pAddr[3:0]] = pData;
        else     memBus.mem_rdata = memArray[pAddr[3:0]];
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int r0;
    int w0;
    int a0;
    int a1;
    cpuBus.req_valid  = 1'b0;
    cpuBus.req_we     = 1'b0;
    cpuBus.req_funct3 = 3'b000;
    cpuBus.req_addr   = '0;
    cpuBus.req_wdata  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready",   {31'b0, cpuBus.req_ready},   32'h1);
    checkOutput("reset resp_valid",  {31'b0, cpuBus.resp_valid},  32'h0);
    checkOutput("reset resp_err",    {31'b0, cpuBus.resp_err},    32'h0);
    checkOutput("reset resp_rdata",  cpuBus.resp_rdata,           32'h0);
    checkOutput("reset mem_request", {31'b0, memBus.mem_request}, 32'h0);
    checkOutput("reset mem_we",      {31'b0, memBus.mem_we},      32'h0);
    checkOutput("reset mem_addr",    memBus.mem_addr,             32'h0);
    checkOutput("reset mem_wdata",   memBus.mem_wdata,            32'h0);
    rst_n = 1'b1;

    applyStimulus("LB 0x0B",  1'b0, F3_B,  32'h0B, 32'h0, 1'b0, 32'hFFFFFF80, 3, 1'b0);
    applyStimulus("LBU 0x0B", 1'b0, F3_BU, 32'h0B, 32'h0, 1'b0, 32'h00000080, 3, 1'b0);
    applyStimulus("LH 0x0A",  1'b0, F3_H,  32'h0A, 32'h0, 1'b0, 32'hFFFF80FF, 3, 1'b0);
    applyStimulus("LHU 0x08", 1'b0, F3_HU, 32'h08, 32'h0, 1'b0, 32'h00007F01, 3, 1'b0);
    applyStimulus("LB 0x09",  1'b0, F3_B,  32'h09, 32'h0, 1'b0, 32'h0000007F, 3, 1'b0);
    applyStimulus("LW 0x08",  1'b0, F3_W,  32'h08, 32'h0, 1'b0, 32'h80FF7F01, 3, 1'b0);
    waitDrain("loads");
    checkOutput("resp_rdata hold after LW", cpuBus.resp_rdata, 32'h80FF7F01);

    r0 = readCount;
    w0 = writeCount;
    applyStimulus("SW 0x08", 1'b1, F3_W, 32'h08, 32'h11223344, 1'b0, 32'h0, 3, 1'b0);
    waitDrain("SW 0x08");
    checkOutput("SW no read",    readCount,  r0);
    checkOutput("SW one write",  writeCount, w0 + 1);
    applyStimulus("LW 0x08 after SW", 1'b0, F3_W, 32'h08, 32'h0, 1'b0, 32'h11223344, 3, 1'b0);
    waitDrain("LW 0x08");

    r0 = readCount;
    w0 = writeCount;
    applyStimulus("SB 0x09", 1'b1, F3_B, 32'h09, 32'h000000AA, 1'b0, 32'h0, 5, 1'b0);
    waitDrain("SB 0x09");
    checkOutput("SB one read",      readCount,  r0 + 1);
    checkOutput("SB one write",     writeCount, w0 + 1);
    checkOutput("SB mem_addr",      lastWrAddr, 32'h2);
    checkOutput("SB mem_wdata",     lastWrData, 32'h1122AA44);
    checkOutput("SB clears rdata",  cpuBus.resp_rdata, 32'h0);

    applyStimulus("SH 0x0A",  1'b1, F3_H,  32'h0A, 32'h1234BEEF, 1'b0, 32'h0, 5, 1'b0);
    applyStimulus("LHU 0x0A", 1'b0, F3_HU, 32'h0A, 32'h0, 1'b0, 32'h0000BEEF, 3, 1'b0);
    applyStimulus("LW 0x08 after SH", 1'b0, F3_W, 32'h08, 32'h0, 1'b0, 32'hBEEFAA44, 3, 1'b0);
    waitDrain("SH");
    checkOutput("SH mem_wdata", lastWrData, 32'hBEEFAA44);

    r0 = readCount;
    w0 = writeCount;
    applyStimulus("SW 0x10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 3, 1'b0);
    waitDrain("SW 0x10");
    checkOutput("SW 0x10 no read",  readCount,  r0);
    checkOutput("SW 0x10 mem_addr", lastWrAddr, 32'h4);
    applyStimulus("LW 0x10", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1'b0);
    waitDrain("LW 0x10");

    r0 = readCount;
    w0 = writeCount;
    applyStimulus("LH 0x03 misaligned",  1'b0, F3_H,   32'h03, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    applyStimulus("SW 0x06 misaligned",  1'b1, F3_W,   32'h06, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    applyStimulus("LW 0x0E misaligned",  1'b0, F3_W,   32'h0E, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    applyStimulus("load funct3 011",     1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    applyStimulus("store funct3 100",    1'b1, 3'b100, 32'h00, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    waitDrain("errors");
    checkOutput("errors issue no memory traffic", readCount + writeCount, r0 + w0);
    checkOutput("error clears rdata", cpuBus.resp_rdata, 32'h0);

    applyStimulus("b2b LW 0x08", 1'b0, F3_W, 32'h08, 32'h0, 1'b0, 32'hBEEFAA44, 3, 1'b1);
    a0 = lastAccept;
    applyStimulus("b2b LW 0x10", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1'b1);
    a1 = lastAccept;
    checkOutput("b2b accept spacing 1", a1 - a0, 32'd4);
    applyStimulus("b2b LW 0x0C", 1'b0, F3_W, 32'h0C, 32'h0, 1'b0, 32'hCAFEF00D, 3, 1'b0);
    checkOutput("b2b accept spacing 2", lastAccept - a1, 32'd4);
    waitDrain("b2b");

    r0 = readCount;
    w0 = writeCount;
    holdOff = 1'b1;
    applyStimulus("SB 0x0C aborted", 1'b1, F3_B, 32'h0C, 32'h00000077, 1'b0, 32'h0, 5, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort req_ready",   {31'b0, cpuBus.req_ready},   32'h1);
    checkOutput("abort resp_valid",  {31'b0, cpuBus.resp_valid},  32'h0);
    checkOutput("abort mem_request", {31'b0, memBus.mem_request}, 32'h0);
    checkOutput("abort mem_we",      {31'b0, memBus.mem_we},      32'h0);
    checkOutput("abort mem_addr",    memBus.mem_addr,             32'h0);
    checkOutput("abort mem_wdata",   memBus.mem_wdata,            32'h0);
    expQ.delete();
    rst_n   = 1'b1;
    holdOff = 1'b0;
    injectValid = 1'b1;
    @(negedge clk);
    injectValid = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("abort single read",  readCount,  r0 + 1);
    checkOutput("abort no write",     writeCount, w0);
    checkOutput("late mem_valid leaves rdata", cpuBus.resp_rdata, 32'h0);
    applyStimulus("LW 0x0C after abort", 1'b0, F3_W, 32'h0C, 32'h0, 1'b0, 32'hCAFEF00D, 3, 1'b0);
    waitDrain("recovery");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
